// File: rtl/battleship_pkg.sv
// Shared Battleship game definitions: state width and game-FSM state encodings.
// Pure type/constant package, no logic and no latency.
// No backpressure; consumers decode the codes as they see fit.
package battleship_pkg;

    // Width of the game-control FSM state bus.
    localparam int STATE_W = 3;

    // Game-control FSM state codes. Code 7 is unused and never issued by the FSM.
    typedef enum logic [STATE_W-1:0] {
        GS_IDLE     = 3'd0,
        GS_P1_SETUP = 3'd1,
        GS_P2_SETUP = 3'd2,
        GS_P1_TURN  = 3'd3,
        GS_P2_TURN  = 3'd4,
        GS_P1_WIN   = 3'd5,
        GS_P2_WIN   = 3'd6
    } game_state_e;

endpackage : battleship_pkg

// File: rtl/can_i_fire.sv
// Decodes the game state into registered per-player fire enables and a shot-phase flag.
// Latency: one clk edge from state to outputs; reset clears outputs asynchronously.
// No backpressure: state is sampled unconditionally every cycle.
module can_i_fire
    import battleship_pkg::*;
#(
    parameter logic [STATE_W-1:0] ST_IDLE     = GS_IDLE,
    parameter logic [STATE_W-1:0] ST_P1_SETUP = GS_P1_SETUP,
    parameter logic [STATE_W-1:0] ST_P2_SETUP = GS_P2_SETUP,
    parameter logic [STATE_W-1:0] ST_P1_TURN  = GS_P1_TURN,
    parameter logic [STATE_W-1:0] ST_P2_TURN  = GS_P2_TURN,
    parameter logic [STATE_W-1:0] ST_P1_WIN   = GS_P1_WIN,
    parameter logic [STATE_W-1:0] ST_P2_WIN   = GS_P2_WIN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] state,
    output logic               p1fire,
    output logic               p2fire,
    output logic               taking_turns
);

    // Named decode of the current state sample.
    logic p1_turn_d;
    logic p2_turn_d;
    logic taking_turns_d;

    logic p1fire_q;
    logic p2fire_q;
    logic taking_turns_q;

    // Combinational decode: only the two turn codes grant permission; setup,
    // idle, win codes and the unused code 7 all decode to non-firing.
    always_comb begin
        p1_turn_d = 1'b0;
        p2_turn_d = 1'b0;
        case (state)
            ST_P1_TURN: p1_turn_d = 1'b1;
            ST_P2_TURN: p2_turn_d = 1'b1;
            ST_IDLE, ST_P1_SETUP, ST_P2_SETUP, ST_P1_WIN, ST_P2_WIN: begin
                p1_turn_d = 1'b0;
                p2_turn_d = 1'b0;
            end
            default: begin
                p1_turn_d = 1'b0;
                p2_turn_d = 1'b0;
            end
        endcase
        // Derived from the two grants so the flag can never disagree with them.
        taking_turns_d = p1_turn_d | p2_turn_d;
    end

    // Output register stage; async active-low reset drops all permissions at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1fire_q       <= 1'b0;
            p2fire_q       <= 1'b0;
            taking_turns_q <= 1'b0;
        end else begin
            p1fire_q       <= p1_turn_d;
            p2fire_q       <= p2_turn_d;
            taking_turns_q <= taking_turns_d;
        end
    end

    assign p1fire       = p1fire_q;
    assign p2fire       = p2fire_q;
    assign taking_turns = taking_turns_q;

`ifndef SYNTHESIS
    // Invariants on the registered outputs: exclusive grants, flag equals their OR.
    always @(posedge clk) begin
        if (reset) begin
            assert (!(p1fire_q && p2fire_q));
            assert (taking_turns_q == (p1fire_q | p2fire_q));
        end
    end
`endif

endmodule : can_i_fire

// File: tb/tb_can_i_fire.sv
// Directed bench for can_i_fire: reset, async reset, turn switching, exits and sweep.
// Outputs are sampled 1 time unit after the rising edge; inputs change there too.
// No backpressure in the design; every cycle is a checkpoint.
module tb_can_i_fire;

    logic       clk;
    logic       reset;
    logic [2:0] state;
    logic       p1fire;
    logic       p2fire;
    logic       taking_turns;

    int checks;
    int errors;

    // Packed view of the outputs: {p1fire, p2fire, taking_turns}.
    wire [2:0] outs = {p1fire, p2fire, taking_turns};

    can_i_fire dut (
        .clk          (clk),
        .reset        (reset),
        .state        (state),
        .p1fire       (p1fire),
        .p2fire       (p2fire),
        .taking_turns (taking_turns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0;
        state = 3'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (outs !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b expected 000", i, outs);
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (outs !== 3'b101) begin
            errors++;
            $display("FAIL reset_release: got %b expected 101", outs);
        end
    endtask

    task automatic test_async_reset();
        state = 3'd4;
        @(posedge clk); #1;
        checks++;
        if (outs !== 3'b011) begin
            errors++;
            $display("FAIL async_pre: got %b expected 011", outs);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== 3'b000) begin
            errors++;
            $display("FAIL async_clear_midcycle: got %b expected 000", outs);
        end
        @(posedge clk); #1;
        checks++;
        if (outs !== 3'b000) begin
            errors++;
            $display("FAIL async_held: got %b expected 000", outs);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (outs !== 3'b011) begin
            errors++;
            $display("FAIL async_resume: got %b expected 011", outs);
        end
    endtask

    task automatic test_turn_sequence();
        logic [2:0] seq [3];
        logic [2:0] exp [3];
        logic [2:0] prev;
        seq[0] = 3'd3; exp[0] = 3'b101;
        seq[1] = 3'd4; exp[1] = 3'b011;
        seq[2] = 3'd3; exp[2] = 3'b101;
        state = 3'd0;
        @(posedge clk); #1;
        prev = 3'b000;
        for (int i = 0; i < 3; i++) begin
            state = seq[i];
            #1;
            // Registered: the new state must not show before the next edge.
            checks++;
            if (outs !== prev) begin
                errors++;
                $display("FAIL turn_latency[%0d]: got %b expected %b", i, outs, prev);
            end
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                checks++;
                if (outs !== exp[i]) begin
                    errors++;
                    $display("FAIL turn_seq[%0d][%0d]: got %b expected %b", i, c, outs, exp[i]);
                end
            end
            prev = exp[i];
        end
    endtask

    task automatic test_leave_shot_phase();
        logic [2:0] seq [4];
        logic [2:0] exp [4];
        seq[0] = 3'd3; exp[0] = 3'b101;
        seq[1] = 3'd2; exp[1] = 3'b000;
        seq[2] = 3'd5; exp[2] = 3'b000;
        seq[3] = 3'd6; exp[3] = 3'b000;
        for (int i = 0; i < 4; i++) begin
            state = seq[i];
            @(posedge clk); #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL leave[%0d] state=%0d: got %b expected %b", i, seq[i], outs, exp[i]);
            end
        end
    endtask

    task automatic test_reentry_after_win();
        logic [2:0] seq [4];
        logic [2:0] exp [4];
        seq[0] = 3'd6; exp[0] = 3'b000;
        seq[1] = 3'd4; exp[1] = 3'b011;
        seq[2] = 3'd3; exp[2] = 3'b101;
        seq[3] = 3'd4; exp[3] = 3'b011;
        for (int i = 0; i < 4; i++) begin
            state = seq[i];
            @(posedge clk); #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL reentry[%0d] state=%0d: got %b expected %b", i, seq[i], outs, exp[i]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [2:0] exp [8];
        exp[0] = 3'b000; exp[1] = 3'b000; exp[2] = 3'b000; exp[3] = 3'b101;
        exp[4] = 3'b011; exp[5] = 3'b000; exp[6] = 3'b000; exp[7] = 3'b000;
        for (int i = 0; i < 8; i++) begin
            state = 3'(i);
            @(posedge clk); #1;
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL sweep code=%0d: got %b expected %b", i, outs, exp[i]);
            end
            checks++;
            if ((p1fire & p2fire) !== 1'b0) begin
                errors++;
                $display("FAIL sweep_excl code=%0d: p1fire=%b p2fire=%b expected not both 1", i, p1fire, p2fire);
            end
            checks++;
            if (taking_turns !== (p1fire | p2fire)) begin
                errors++;
                $display("FAIL sweep_or code=%0d: taking_turns=%b expected %b", i, taking_turns, p1fire | p2fire);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        state  = 3'd0;
        test_reset();
        test_async_reset();
        test_turn_sequence();
        test_leave_shot_phase();
        test_reentry_after_win();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net: the run is only a few hundred cycles long.
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, expected finish before 50000");
        $fatal(1);
    end

endmodule : tb_can_i_fire
